// File: rtl/decoder_pipe.sv
// Pipelined index-to-one-hot decoder behind a 2-entry skid buffer.
// Optional macro DECODER_PIPE_CNT_EN adds out_cnt, a saturating error-word counter.
module decoder_pipe #(
   parameter int IN_W       = 3,
   parameter int NUM_OUT    = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   input  logic               in_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_data,
   output logic               out_err
`ifdef DECODER_PIPE_CNT_EN
   ,
   output logic [15:0]        out_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [NUM_OUT-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

   state_t             state;
   logic               rdy_q;
   logic [NUM_OUT-1:0] hd_data;
   logic               hd_err;
   logic [NUM_OUT-1:0] sk_data;
   logic               sk_err;

   logic [31:0]        idx;
   logic [NUM_OUT-1:0] raw;
   logic [NUM_OUT-1:0] dec_word;
   logic               dec_err;
   logic               acc;
   logic               xfer;

   assign idx = {{(32-IN_W){1'b0}}, in_data};

   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         raw[i] = in_en && (idx == 32'(i));
      end
      dec_err  = in_en && (idx >= 32'(NUM_OUT));
      dec_word = raw ^ IDLE;
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state != EMPTY);
   assign out_data  = hd_data;
   assign out_err   = hd_err;

   assign acc  = in_valid && rdy_q;
   assign xfer = out_valid && out_ready;

   // hd_* is the presented word; sk_* only holds the second word while FULL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         rdy_q   <= 1'b0;
         hd_data <= IDLE;
         hd_err  <= 1'b0;
         sk_data <= IDLE;
         sk_err  <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               rdy_q <= 1'b1;
               if (acc) begin
                  hd_data <= dec_word;
                  hd_err  <= dec_err;
                  state   <= ONE;
               end
            end
            ONE: begin
               rdy_q <= 1'b1;
               if (acc && xfer) begin
                  hd_data <= dec_word;
                  hd_err  <= dec_err;
               end else if (acc) begin
                  sk_data <= dec_word;
                  sk_err  <= dec_err;
                  rdy_q   <= 1'b0;
                  state   <= FULL;
               end else if (xfer) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (xfer) begin
                  hd_data <= sk_data;
                  hd_err  <= sk_err;
                  rdy_q   <= 1'b1;
                  state   <= ONE;
               end
            end
            default: begin
               rdy_q <= 1'b1;
               state <= EMPTY;
            end
         endcase
      end
   end

`ifdef DECODER_PIPE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt <= 16'd0;
      end else if (xfer && hd_err && (out_cnt != 16'hFFFF)) begin
         out_cnt <= out_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe: directed scenarios plus a
// randomized handshake run against a queue-based reference model.
module tb_decoder_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_en = 1'b0;
   logic [2:0] in_data = 3'd0;
   logic       out_ready = 1'b0;

   logic       in_ready, out_valid, out_err;
   logic [5:0] out_data;
   logic       in_ready_n, out_valid_n, out_err_n;
   logic [5:0] out_data_n;
`ifdef DECODER_PIPE_CNT_EN
   logic [15:0] out_cnt, out_cnt_n;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decoder_pipe #(.IN_W(3), .NUM_OUT(6), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_en(in_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err)
`ifdef DECODER_PIPE_CNT_EN
      , .out_cnt(out_cnt)
`endif
   );

   decoder_pipe #(.IN_W(3), .NUM_OUT(6), .ACTIVE_LOW(1)) dut_n (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_n),
      .in_data(in_data), .in_en(in_en),
      .out_valid(out_valid_n), .out_ready(out_ready),
      .out_data(out_data_n), .out_err(out_err_n)
`ifdef DECODER_PIPE_CNT_EN
      , .out_cnt(out_cnt_n)
`endif
   );

   // Expected decode from the rules: {err, word}
   function automatic logic [6:0] ref_dec(input logic en, input int d);
      if (!en) return 7'd0;
      if (d < 6) return {1'b0, 6'(1 << d)};
      return 7'b1_000000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_chk += 5;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid);
      end
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_ready got=%b exp=0", in_ready);
      end
      if (out_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_err got=%b exp=0", out_err);
      end
      if (out_data !== 6'h00) begin
         n_fail++; $display("FAIL rst_data got=%h exp=00", out_data);
      end
      if (out_data_n !== 6'h3F) begin
         n_fail++; $display("FAIL rst_data_n got=%h exp=3f", out_data_n);
      end
      rst = 1'b0;
      tick();
      n_chk += 2;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rel_ready got=%b exp=1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rel_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp;
      out_ready = 1'b1;
      for (int d = 0; d < 6; d++) begin
         in_valid = 1'b1; in_en = 1'b1; in_data = 3'(d);
         tick();
         exp = 6'(1 << d);
         n_chk++;
         if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1",
                     d, out_valid, out_data, in_ready, exp);
         end
      end
      in_valid = 1'b0;
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_err();
      out_ready = 1'b1;
      for (int d = 6; d < 8; d++) begin
         in_valid = 1'b1; in_en = 1'b1; in_data = 3'(d);
         tick();
         n_chk++;
         if (out_valid !== 1'b1 || out_data !== 6'h00 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_%0d got v=%b d=%h e=%b exp v=1 d=00 e=1",
                     d, out_valid, out_data, out_err);
         end
      end
      in_valid = 1'b0;
      tick();
`ifdef DECODER_PIPE_CNT_EN
      n_chk++;
      if (out_cnt !== 16'd2) begin
         n_fail++; $display("FAIL err_cnt got=%0d exp=2", out_cnt);
      end
`endif
   endtask

   task automatic test_enable_polarity();
      out_ready = 1'b1;
      in_valid = 1'b1; in_en = 1'b0; in_data = 3'd2;
      tick();
      n_chk++;
      if (out_data !== 6'h00 || out_err !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL en_off got d=%h e=%b v=%b exp d=00 e=0 v=1",
                  out_data, out_err, out_valid);
      end
      in_en = 1'b1;
      tick();
      n_chk += 2;
      if (out_data_n !== 6'h3B || out_err_n !== 1'b0) begin
         n_fail++;
         $display("FAIL active_low got d=%h e=%b exp d=3b e=0",
                  out_data_n, out_err_n);
      end
      if (out_data !== 6'h04) begin
         n_fail++; $display("FAIL en_on got=%h exp=04", out_data);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      in_valid = 1'b1; in_en = 1'b1; in_data = 3'd3;
      tick();
      n_chk++;
      if (out_data !== 6'h08 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_1 got d=%h r=%b exp d=08 r=1", out_data, in_ready);
      end
      in_data = 3'd4;
      tick();
      n_chk++;
      if (out_data !== 6'h08 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_full got d=%h r=%b v=%b exp d=08 r=0 v=1",
                  out_data, in_ready, out_valid);
      end
      in_valid = 1'b0; in_data = 3'd1;
      tick();
      n_chk++;
      if (out_data !== 6'h08 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL stall_hold got d=%h r=%b exp d=08 r=0", out_data, in_ready);
      end
      out_ready = 1'b1;
      tick();
      n_chk++;
      if (out_data !== 6'h10 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_rel got d=%h r=%b v=%b exp d=10 r=1 v=1",
                  out_data, in_ready, out_valid);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_empty got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_en = 1'b1; in_data = 3'd1;
      tick();
      in_data = 3'd2;
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst got v=%b r=%b exp v=0 r=0", out_valid, in_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_rel got r=%b v=%b exp r=1 v=0", in_ready, out_valid);
      end
      out_ready = 1'b1;
      repeat (2) tick();
      n_chk++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_stale got v=%b exp=0", out_valid);
      end
   endtask

   task automatic test_random();
      logic [6:0] q[$];
      logic [6:0] exp;
      int         err_xfers = 0;
      bit         xf, ac;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      for (int c = 0; c < 10000; c++) begin
         if (c >= 9990) begin
            in_valid = 1'b0;
            out_ready = 1'b1;
         end else begin
            in_valid  = 1'($urandom % 2);
            out_ready = 1'($urandom % 2);
         end
         in_data = 3'($urandom);
         in_en   = ($urandom % 4) != 0;
         #1;
         n_chk++;
         if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
            n_fail++;
            $display("FAIL rnd_flags c=%0d got v=%b r=%b exp occ=%0d",
                     c, out_valid, in_ready, q.size());
         end
         xf = out_valid && out_ready;
         ac = in_valid && in_ready;
         if (xf && q.size() != 0) begin
            exp = q.pop_front();
            n_chk++;
            if ({out_err, out_data} !== exp) begin
               n_fail++;
               $display("FAIL rnd_data c=%0d got e=%b d=%h exp e=%b d=%h",
                        c, out_err, out_data, exp[6], exp[5:0]);
            end
            if (exp[6]) err_xfers++;
         end
         if (ac) q.push_back(ref_dec(in_en, int'(in_data)));
         tick();
      end
      n_chk++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rnd_drain got left=%0d v=%b exp left=0 v=0", q.size(), out_valid);
      end
`ifdef DECODER_PIPE_CNT_EN
      n_chk++;
      if (out_cnt !== 16'(err_xfers)) begin
         n_fail++; $display("FAIL rnd_cnt got=%0d exp=%0d", out_cnt, err_xfers);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_err();
      test_enable_polarity();
      test_stall();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 3, meaning encoded index width (1..8).
REQ-002 SHALL have parameter NUM_OUT, default 8, meaning number of one-hot output lines (2..2**IN_W).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0, meaning out_data polarity (1 = selected line driven 0, others 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream index valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an index.
REQ-008 SHALL have port in_data  input  IN_W  encoded index.
REQ-009 SHALL have port in_en  input  1  decode enable, sampled with in_data; 0 = no line selected.
REQ-010 SHALL have port out_valid  output  1  decoded word valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts decoded word.
REQ-012 SHALL have port out_data  output  NUM_OUT  one-hot (or one-cold) decoded word.
REQ-013 SHALL have port out_err  output  1  index of current word was >= NUM_OUT.

Function
REQ-014 SHALL accept an input when in_valid && in_ready on a rising clk edge; SHALL transfer an output when out_valid && out_ready.
REQ-015 SHALL decode: in_en=1 and in_data<NUM_OUT -> bit in_data set, others clear, out_err=0.
REQ-016 SHALL decode in_en=1 and in_data>=NUM_OUT -> all lines clear, out_err=1.
REQ-017 SHALL decode in_en=0 -> all lines clear, out_err=0, regardless of in_data.
REQ-018 SHALL apply ACTIVE_LOW=1 as bitwise inversion of out_data only; out_err polarity unchanged.
REQ-019 SHALL register decoded results in a 2-entry skid buffer with states EMPTY, ONE, FULL.
REQ-020 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without output transfer; ONE->EMPTY on output transfer without accept; ONE->ONE on simultaneous accept and transfer; FULL->ONE on output transfer.
REQ-021 SHALL have latency of exactly 1 cycle: word accepted at edge N is on out_data with out_valid=1 after edge N when buffer was EMPTY.
REQ-022 SHALL drive in_ready = (state != FULL) from registered state only (no combinational path from out_ready).
REQ-023 SHALL drive out_valid = (state != EMPTY); out_data/out_err SHALL hold stable while out_valid && !out_ready.
REQ-024 SHALL preserve order; no word dropped or duplicated, including with out_ready toggling every cycle.
REQ-025 SHALL sustain one word per cycle when out_ready held high.
REQ-026 SHALL ignore in_data/in_en when no accept occurs.

Reset
REQ-027 SHALL, while rst=1, force state EMPTY, out_valid=0, in_ready=0, out_err=0, out_data all-inactive (0s, or 1s if ACTIVE_LOW).
REQ-028 SHALL discard buffered words on reset mid-operation; in_ready=1 on first edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro DECODER_PIPE_CNT_EN defined, add output port out_cnt (16 bits): count of output transfers with out_err=1, saturating at 16'hFFFF, reset to 0.
REQ-030 SHALL, without DECODER_PIPE_CNT_EN, omit out_cnt and its logic; all other behaviour identical.

Verification (IN_W=3, NUM_OUT=6, ACTIVE_LOW=0 unless stated)
REQ-031 SHALL cover: out_ready=1, in_data=0..5 back-to-back, in_en=1 -> out_data 01,02,04,08,10,20 one cycle later, no bubbles.
REQ-032 SHALL cover: in_data=6 then 7, in_en=1 -> out_data=00 with out_err=1 both words; with CNT_EN out_cnt=2.
REQ-033 SHALL cover: out_ready=0, push 3 and 4 -> in_ready=0 after second accept, out_data=08 held; out_ready=1 -> 08 then 10, in_ready=1.
REQ-034 SHALL cover: in_en=0, in_data=2 -> out_data=00, out_err=0; ACTIVE_LOW=1, in_data=2, in_en=1 -> out_data=3B.
REQ-035 SHALL cover: buffer FULL, rst pulsed mid-cycle -> out_valid=0 immediately, in_ready=1 after release, no stale word emitted.
REQ-036 SHALL cover: random in_valid/out_ready 10000 cycles -> output sequence equals decoded input sequence, scoreboard-checked.
